fourb5b_uart_bridge: RTL
========================

Name: fourb5b_uart_bridge

Overview:
- Receives 4B/5B-encoded serial frames on the RS-232 DTE line and decodes each frame to one byte.
- Buffers decoded bytes in a FIFO and retransmits them to the PC as standard 8N1 UART.
- Generalised successor of the fixed 9600-baud bridge:
  - parametrised clocks, baud rates, oversampling and FIFO depth;
  - majority-vote sampling;
  - error flags that never halt the system.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- RX_BAUD, 9600, encoded-line baud rate.
- TX_BAUD, 9600, PC-side baud rate.
- OVS, 16, RX oversampling factor (even, >=8).
- FIFO_DEPTH, 8, byte FIFO entries (power of 2, >=2).

Ports:
- CLK_50M  input  1  system clock, all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- RS232_DTE_RXD  input  1  encoded serial input, asynchronous, idle high.
- RS232_DCE_TXD  output  1  8N1 serial output to PC, idle high.
- LED  output  8  last byte started on TX.
- ERR_CLR  input  1  synchronous pulse, clears all sticky flags.
- FRAME_ERR  output  1  sticky: stop bit sampled low.
- SYM_ERR  output  1  sticky: invalid 5b symbol received.
- OVERFLOW  output  1  sticky: byte dropped because the FIFO was full.
- FIFO_LEVEL  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): RS232_DCE_TXD=1, LED=0, all flags=0, FIFO_LEVEL=0. Both FSMs go to IDLE.
- Reset mid-frame: TXD returns high immediately and the partial RX frame is discarded.
- RX input: 2-flop synchroniser. Tick divider = CLK_HZ/(RX_BAUD*OVS), integer truncation. Divider is held at 0 while RX FSM is IDLE.
- RX frame on the wire, LSB first: start(0), low-nibble symbol s0..s4, high-nibble symbol s0..s4, stop(1). 12 bit times total.
- RX FSM:
  - IDLE: a falling edge on the synced line moves to START.
  - START: at tick OVS/2, a majority of samples OVS/2-1, OVS/2, OVS/2+1. Low goes to DATA. High (glitch) returns to IDLE with no flag.
  - DATA: 10 bits, each taken as the 3-sample majority centred on the bit; then go to STOP.
  - STOP: majority high goes to DECODE. Majority low sets FRAME_ERR, discards the frame, and returns to IDLE.
  - DECODE: 1 cycle, then IDLE. The line is re-armed within the stop-bit period.
- Symbol table (s4..s0 -> nibble): 11110=0, 01001=1, 10100=2, 10101=3, 01010=4, 01011=5, 01110=6, 01111=7, 10010=8, 10011=9, 10110=A, 10111=B, 11010=C, 11011=D, 11100=E, 11101=F.
- Decoded byte = {high nibble, low nibble}. The push into the FIFO happens in the DECODE cycle.
- FIFO:
  - Push while full: byte dropped, OVERFLOW set, contents unchanged.
  - Push and pop in the same cycle while full: both succeed and the level is unchanged.
  - Pop while empty never occurs.
- TX:
  - Divider = CLK_HZ/TX_BAUD.
  - States IDLE -> START -> DATA(8, LSB first) -> STOP -> IDLE.
  - In IDLE with the FIFO non-empty: pop and load, LED updates, TXD goes low on the next clock.
  - Back-to-back bytes: no extra idle bit between the STOP and the next START.
- Flags:
  - Set has priority over ERR_CLR in the same cycle.
  - Flags never stop reception or transmission.

Optional Feature:
- Macro: STRICT_SYMBOL_EN.
- Defined: a frame containing any symbol outside the table sets SYM_ERR and is dropped (no FIFO push).
- Undefined: an invalid symbol decodes to nibble F, the byte is pushed, and SYM_ERR still sets.

Test Plan:
- Encoded 0x3A, line bits 0,0,1,1,0,1,1,0,1,0,1,1 at 9600 -> TXD carries 8N1 0x3A, LED=0x3A, all flags 0, FIFO_LEVEL returns to 0.
- 40 us low pulse on an idle line -> no frame, TXD stays 1, flags 0.
- 0x00 frame with stop bit forced 0 -> FRAME_ERR=1, nothing transmitted. Next valid 0x55 frame -> 0x55 transmitted. ERR_CLR pulse -> FRAME_ERR=0.
- Low symbol 00000 and high symbol 3 -> with STRICT_SYMBOL_EN: SYM_ERR=1, no TX. Without it: 0x3F transmitted, SYM_ERR=1.
- TX_BAUD=RX_BAUD/4, 12 back-to-back frames 0x01..0x0C -> FIFO_LEVEL reaches 8, OVERFLOW=1, surviving bytes transmitted in order with no gaps.
- RST_N asserted mid-TX of 0xA5 -> TXD=1 within the same cycle, FIFO_LEVEL=0; after release the line is idle until the next frame.

Source files
------------

// File: rtl/fourb5b_uart_bridge.sv
// 4B/5B serial frame receiver -> byte FIFO -> 8N1 UART retransmitter with sticky, non-halting error flags.
// Optional macro STRICT_SYMBOL_EN: frames with an invalid 5b symbol are dropped instead of decoding to nibble F.
module fourb5b_uart_bridge #(
  parameter int CLK_HZ     = 50000000,
  parameter int RX_BAUD    = 9600,
  parameter int TX_BAUD    = 9600,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        CLK_50M,
  input  logic                        RST_N,
  input  logic                        RS232_DTE_RXD,
  output logic                        RS232_DCE_TXD,
  output logic [7:0]                  LED,
  input  logic                        ERR_CLR,
  output logic                        FRAME_ERR,
  output logic                        SYM_ERR,
  output logic                        OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
);

  localparam int RX_DIV = CLK_HZ / (RX_BAUD * OVS);
  localparam int TX_DIV = CLK_HZ / TX_BAUD;
  localparam int RXDW   = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam int TXDW   = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam int SW     = $clog2(OVS);
  localparam int AW     = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_STOP   = 3'd3,
    RX_DECODE = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Returns {valid, nibble}; symbols outside the table give {0, F}.
  function automatic logic [4:0] sym_decode(input logic [4:0] sym);
    logic [4:0] res;
    case (sym)
      5'b11110: res = {1'b1, 4'h0};
      5'b01001: res = {1'b1, 4'h1};
      5'b10100: res = {1'b1, 4'h2};
      5'b10101: res = {1'b1, 4'h3};
      5'b01010: res = {1'b1, 4'h4};
      5'b01011: res = {1'b1, 4'h5};
      5'b01110: res = {1'b1, 4'h6};
      5'b01111: res = {1'b1, 4'h7};
      5'b10010: res = {1'b1, 4'h8};
      5'b10011: res = {1'b1, 4'h9};
      5'b10110: res = {1'b1, 4'hA};
      5'b10111: res = {1'b1, 4'hB};
      5'b11010: res = {1'b1, 4'hC};
      5'b11011: res = {1'b1, 4'hD};
      5'b11100: res = {1'b1, 4'hE};
      5'b11101: res = {1'b1, 4'hF};
      default:  res = {1'b0, 4'hF};
    endcase
    return res;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic            rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t       rx_state_r, rx_state_nxt_s;
  logic [RXDW-1:0] rx_div_r;
  logic [SW-1:0]   rx_smp_r, rx_smp_nxt_s;
  logic [2:0]      rx_vote_r;
  logic [3:0]      rx_bit_r;
  logic [9:0]      rx_shift_r;
  logic            rx_tick_s, rx_take_s, rx_decide_s, rx_maj_s;
  logic [4:0]      lo_dec_s, hi_dec_s;
  logic            push_s, frame_err_set_s, sym_err_set_s, ovf_set_s;

  logic [7:0]      fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [AW:0]     level_r;
  logic            full_s, empty_s, wr_en_s, pop_s;

  tx_state_t       tx_state_r, tx_state_nxt_s;
  logic [TXDW-1:0] tx_cnt_r;
  logic [2:0]      tx_bit_r;
  logic [7:0]      tx_shift_r, led_r;
  logic            tx_end_s, txd_nxt_s, txd_r;
  logic            frame_err_r, sym_err_r, ovf_r;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= RS232_DTE_RXD;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Oversampling strobes: three samples around the bit centre, decision on the last one.
  always_comb begin
    rx_tick_s    = (rx_div_r == RXDW'(RX_DIV - 1));
    rx_smp_nxt_s = (rx_smp_r == SW'(OVS - 1)) ? {SW{1'b0}} : rx_smp_r + SW'(1);
    rx_take_s    = rx_tick_s && (rx_smp_nxt_s >= SW'(OVS / 2 - 1)) && (rx_smp_nxt_s <= SW'(OVS / 2 + 1));
    rx_decide_s  = rx_tick_s && (rx_smp_nxt_s == SW'(OVS / 2 + 1));
    rx_maj_s     = maj3(rx_vote_r[1], rx_vote_r[0], rx_sync_r);
    lo_dec_s     = sym_decode(rx_shift_r[4:0]);
    hi_dec_s     = sym_decode(rx_shift_r[9:5]);
  end

  always_comb begin
    rx_state_nxt_s  = rx_state_r;
    frame_err_set_s = 1'b0;
    sym_err_set_s   = 1'b0;
    push_s          = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (rx_prev_r && !rx_sync_r) rx_state_nxt_s = RX_START;
        else                         rx_state_nxt_s = RX_IDLE;
      end
      RX_START: begin
        if (rx_decide_s) rx_state_nxt_s = rx_maj_s ? RX_IDLE : RX_DATA;
        else             rx_state_nxt_s = RX_START;
      end
      RX_DATA: begin
        if (rx_decide_s && (rx_bit_r == 4'd9)) rx_state_nxt_s = RX_STOP;
        else                                   rx_state_nxt_s = RX_DATA;
      end
      RX_STOP: begin
        if (rx_decide_s) begin
          rx_state_nxt_s  = rx_maj_s ? RX_DECODE : RX_IDLE;
          frame_err_set_s = !rx_maj_s;
        end else begin
          rx_state_nxt_s = RX_STOP;
        end
      end
      RX_DECODE: begin
        rx_state_nxt_s = RX_IDLE;
        sym_err_set_s  = !(lo_dec_s[4] && hi_dec_s[4]);
`ifdef STRICT_SYMBOL_EN
        push_s         = lo_dec_s[4] && hi_dec_s[4];
`else
        push_s         = 1'b1;
`endif
      end
      default: rx_state_nxt_s = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) rx_state_r <= RX_IDLE;
    else        rx_state_r <= rx_state_nxt_s;
  end

  // Divider and sample counters stay cleared in IDLE so each frame is timed from its own start edge.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      rx_div_r   <= {RXDW{1'b0}};
      rx_smp_r   <= {SW{1'b0}};
      rx_vote_r  <= 3'b000;
      rx_bit_r   <= 4'd0;
      rx_shift_r <= 10'd0;
    end else if (rx_state_r == RX_IDLE) begin
      rx_div_r  <= {RXDW{1'b0}};
      rx_smp_r  <= {SW{1'b0}};
      rx_vote_r <= 3'b000;
      rx_bit_r  <= 4'd0;
    end else begin
      rx_div_r <= rx_tick_s ? {RXDW{1'b0}} : rx_div_r + RXDW'(1);
      if (rx_tick_s) rx_smp_r <= rx_smp_nxt_s;
      if (rx_take_s) rx_vote_r <= {rx_vote_r[1:0], rx_sync_r};
      if ((rx_state_r == RX_DATA) && rx_decide_s) begin
        rx_shift_r <= {rx_maj_s, rx_shift_r[9:1]};
        rx_bit_r   <= rx_bit_r + 4'd1;
      end
    end
  end

  // A full FIFO still accepts a push when the TX side pops in the same cycle.
  always_comb begin
    full_s    = (level_r == (AW + 1)'(FIFO_DEPTH));
    empty_s   = (level_r == {(AW + 1){1'b0}});
    wr_en_s   = push_s && (!full_s || pop_s);
    ovf_set_s = push_s && full_s && !pop_s;
  end

  always_ff @(posedge CLK_50M) begin
    if (wr_en_s) fifo_mem_r[wr_ptr_r] <= {hi_dec_s[3:0], lo_dec_s[3:0]};
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW + 1){1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)   rd_ptr_r <= rd_ptr_r + AW'(1);
      level_r <= level_r + (AW + 1)'(wr_en_s) - (AW + 1)'(pop_s);
    end
  end

  // TXD is registered from the next state so the start bit appears on the clock after the pop.
  always_comb begin
    tx_end_s       = (tx_cnt_r == TXDW'(TX_DIV - 1));
    tx_state_nxt_s = tx_state_r;
    pop_s          = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        if (!empty_s) begin
          tx_state_nxt_s = TX_START;
          pop_s          = 1'b1;
        end else begin
          tx_state_nxt_s = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_end_s) tx_state_nxt_s = TX_DATA;
        else          tx_state_nxt_s = TX_START;
      end
      TX_DATA: begin
        if (tx_end_s && (tx_bit_r == 3'd7)) tx_state_nxt_s = TX_STOP;
        else                                tx_state_nxt_s = TX_DATA;
      end
      TX_STOP: begin
        if (tx_end_s && !empty_s) begin
          tx_state_nxt_s = TX_START;
          pop_s          = 1'b1;
        end else if (tx_end_s) begin
          tx_state_nxt_s = TX_IDLE;
        end else begin
          tx_state_nxt_s = TX_STOP;
        end
      end
      default: tx_state_nxt_s = TX_IDLE;
    endcase
    case (tx_state_nxt_s)
      TX_START: txd_nxt_s = 1'b0;
      TX_DATA: begin
        if ((tx_state_r == TX_DATA) && tx_end_s) txd_nxt_s = tx_shift_r[1];
        else                                     txd_nxt_s = tx_shift_r[0];
      end
      default:  txd_nxt_s = 1'b1;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= {TXDW{1'b0}};
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'd0;
      led_r      <= 8'd0;
      txd_r      <= 1'b1;
    end else begin
      tx_state_r <= tx_state_nxt_s;
      txd_r      <= txd_nxt_s;
      if (pop_s) begin
        tx_shift_r <= fifo_mem_r[rd_ptr_r];
        led_r      <= fifo_mem_r[rd_ptr_r];
        tx_cnt_r   <= {TXDW{1'b0}};
        tx_bit_r   <= 3'd0;
      end else if (tx_state_r != TX_IDLE) begin
        tx_cnt_r <= tx_end_s ? {TXDW{1'b0}} : tx_cnt_r + TXDW'(1);
        if ((tx_state_r == TX_DATA) && tx_end_s) begin
          tx_shift_r <= {1'b0, tx_shift_r[7:1]};
          tx_bit_r   <= tx_bit_r + 3'd1;
        end
      end else begin
        tx_cnt_r <= {TXDW{1'b0}};
      end
    end
  end

  // Sticky flags: a set in the same cycle as ERR_CLR wins.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      frame_err_r <= 1'b0;
      sym_err_r   <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      frame_err_r <= frame_err_set_s | (frame_err_r & ~ERR_CLR);
      sym_err_r   <= sym_err_set_s   | (sym_err_r   & ~ERR_CLR);
      ovf_r       <= ovf_set_s       | (ovf_r       & ~ERR_CLR);
    end
  end

  assign RS232_DCE_TXD = txd_r;
  assign LED           = led_r;
  assign FRAME_ERR     = frame_err_r;
  assign SYM_ERR       = sym_err_r;
  assign OVERFLOW      = ovf_r;
  assign FIFO_LEVEL    = level_r;

endmodule
